// File: rtl/alu_operand_stage_pkg.sv
// Shared constants and types for the ALU operand stage (register file, operand latches, status flags).
package alu_operand_stage_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned REG_COUNT = 2 ** ADDR_W;

    localparam logic S_SEL_REG = 1'b0;
    localparam logic S_SEL_IMM = 1'b1;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
    } flags_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Datapath-side bus of the operand stage: write-back, operand read request, flags, and registered results.
interface alu_operand_stage_if;
    import alu_operand_stage_pkg::*;

    logic              W_En;
    logic [ADDR_W-1:0] W_Addr;
    logic [DATA_W-1:0] W_Data;
    logic [ADDR_W-1:0] R_Addr;
    logic [ADDR_W-1:0] S_Addr;
    logic              S_Sel;
    logic [DATA_W-1:0] Imm;
    logic              Rd_En;
    logic              Flag_Ld;
    logic              N_in;
    logic              Z_in;
    logic              C_in;
    logic [DATA_W-1:0] R;
    logic [DATA_W-1:0] S;
    logic              Op_Valid;
    logic              N;
    logic              Z;
    logic              C;

    modport master (
        output W_En, W_Addr, W_Data, R_Addr, S_Addr, S_Sel, Imm, Rd_En,
               Flag_Ld, N_in, Z_in, C_in,
        input  R, S, Op_Valid, N, Z, C
    );

    modport slave (
        input  W_En, W_Addr, W_Data, R_Addr, S_Addr, S_Sel, Imm, Rd_En,
               Flag_Ld, N_in, Z_in, C_in,
        output R, S, Op_Valid, N, Z, C
    );

endinterface

// File: rtl/alu_operand_stage_regfile8x16.sv
// 8 x 16 register file, one write port and two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module alu_operand_stage_regfile8x16
    import alu_operand_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_c,
    output logic [DATA_W-1:0] rdata_b_c
);

    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [DATA_W-1:0] regs_d [REG_COUNT];

    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Write-through: a read of the address being written sees the new data.
    assign rdata_a_c = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
    assign rdata_b_c = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];
`else
    assign rdata_a_c = regs_q[raddr_a_i];
    assign rdata_b_c = regs_q[raddr_b_i];
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage in front of the ALU: register file, R/S operand latches with immediate mux,
// Op_Valid pulse and N/Z/C status register. Optional write forwarding via REGFILE_BYPASS_EN.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    alu_operand_stage_if.slave  bus
);

    logic [DATA_W-1:0] rd_r_c;
    logic [DATA_W-1:0] rd_s_c;

    logic [DATA_W-1:0] r_q, r_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic              op_valid_q, op_valid_d;
    flags_t            flags_q, flags_d;

    alu_operand_stage_regfile8x16 u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we_i      (bus.W_En),
        .waddr_i   (bus.W_Addr),
        .wdata_i   (bus.W_Data),
        .raddr_a_i (bus.R_Addr),
        .raddr_b_i (bus.S_Addr),
        .rdata_a_c (rd_r_c),
        .rdata_b_c (rd_s_c)
    );

    always_comb begin
        r_d        = r_q;
        s_d        = s_q;
        flags_d    = flags_q;
        op_valid_d = bus.Rd_En;
        if (bus.Rd_En) begin
            r_d = rd_r_c;
            s_d = (bus.S_Sel == S_SEL_REG) ? rd_s_c : bus.Imm;
        end
        if (bus.Flag_Ld) begin
            flags_d = '{n: bus.N_in, z: bus.Z_in, c: bus.C_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q        <= '0;
            s_q        <= '0;
            op_valid_q <= 1'b0;
            flags_q    <= '0;
        end else begin
            r_q        <= r_d;
            s_q        <= s_d;
            op_valid_q <= op_valid_d;
            flags_q    <= flags_d;
        end
    end

    assign bus.R        = r_q;
    assign bus.S        = s_q;
    assign bus.Op_Valid = op_valid_q;
    assign bus.N        = flags_q.n;
    assign bus.Z        = flags_q.z;
    assign bus.C        = flags_q.c;

endmodule
